// File: rtl/complex_arith_pkg.sv
// rtl/complex_arith_pkg.sv - shared widths and round/saturate helper for the complex arithmetic datapath
package complex_arith_pkg;

    localparam int Y_W   = 36;
    localparam int A_W   = 18;
    localparam int B_W   = 18;
    localparam int RND_W = Y_W + 1;

    typedef struct packed {
        logic                    sat;
        logic signed [RND_W-1:0] val;
    } rs_t;

    // Round half-up (ties toward +inf) by dropping shift fraction bits, then clamp to out_w signed bits.
    // One extra bit of headroom keeps y + 2^(shift-1) from wrapping.
    function automatic rs_t round_sat(input logic signed [Y_W-1:0] y,
                                      input int shift,
                                      input int out_w);
        logic signed [RND_W-1:0] wide;
        logic signed [RND_W-1:0] half;
        logic signed [RND_W-1:0] rounded;
        logic signed [RND_W-1:0] hi;
        logic signed [RND_W-1:0] lo;
        rs_t r;
        wide    = {y[Y_W-1], y};
        half    = RND_W'(1) <<< (shift - 1);
        rounded = (wide + half) >>> shift;
        hi      = (RND_W'(1) <<< (out_w - 1)) - RND_W'(1);
        lo      = -(RND_W'(1) <<< (out_w - 1));
        if (rounded > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end else if (rounded < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end else begin
            r.val = rounded;
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - synchronous first-word-fall-through FIFO with wrap-bit pointers
module sync_fifo_fwft #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid   = ~empty;
    assign do_pop  = pop & ~empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer and storage update; storage is cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/complex_result_collector.sv
// rtl/complex_result_collector.sv - captures, rounds and queues results from the ce-gated arithmetic pipeline
module complex_result_collector
    import complex_arith_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int SHIFT   = 10,
    parameter int OUT_W   = 18,
    parameter int DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic signed [Y_W-1:0]   Y,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    full,
    output logic                    drop,
    output logic [7:0]              drop_cnt
);
    logic [LATENCY-1:0] vld;
    logic               push;
    logic               pop;
    logic               drop_ev;
    rs_t                rs;
    logic [OUT_W:0]     wdata;
    logic [OUT_W:0]     rdata;

    assign push    = ce & vld[LATENCY-1];
    assign pop     = out_valid & out_ready;
    assign drop_ev = push & full & ~pop;

    // Valid delay line mirrors the arithmetic pipeline, advancing only on ce cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else if (ce) begin
            vld[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // Round and saturate the current Y so it is ready when the delay line says it is valid.
    always_comb begin
        rs    = round_sat(Y, SHIFT, OUT_W);
        wdata = {rs.sat, rs.val[OUT_W-1:0]};
    end

    sync_fifo_fwft #(
        .WIDTH (OUT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .valid (out_valid),
        .full  (full)
    );

    assign out_sat  = rdata[OUT_W];
    assign out_data = rdata[OUT_W-1:0];

    // Sticky overflow flag and saturating count of results lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop     <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (drop_ev) begin
            drop <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_complex_result_collector.sv
// tb/tb_complex_result_collector.sv - directed self-checking bench for complex_result_collector
module tb_complex_result_collector;

    logic               clk = 1'b0;
    logic               rst;
    logic               ce;
    logic               in_valid;
    logic signed [35:0] Y;
    logic signed [17:0] out_data;
    logic               out_sat;
    logic               out_valid;
    logic               out_ready;
    logic               full;
    logic               drop;
    logic [7:0]         drop_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic signed [35:0] y;
        int                 exp_d;
        int                 exp_s;
    } vec_t;

    vec_t vecs [12];

    complex_result_collector dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .Y         (Y),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .drop      (drop),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [35:0] ymul(input int n);
        return 36'(longint'(n) * 1024);
    endfunction

    initial begin
        vecs[0]  = '{36'sd1536,                 2,       0};
        vecs[1]  = '{-36'sd1536,               -1,       0};
        vecs[2]  = '{36'sd1535,                 1,       0};
        vecs[3]  = '{-36'sd2048,               -2,       0};
        vecs[4]  = '{36'sd17179869184,          131071,  1};
        vecs[5]  = '{36'h800000000,            -131072,  1};
        vecs[6]  = '{36'sd134216704,            131071,  0};
        vecs[7]  = '{36'sd512,                  1,       0};
        vecs[8]  = '{-36'sd512,                 0,       0};
        vecs[9]  = '{36'sd134217216,            131071,  1};
        vecs[10] = '{-36'sd134218240,          -131072,  0};
        vecs[11] = '{-36'sd134218241,          -131072,  1};

        rst = 1'b1; ce = 1'b0; in_valid = 1'b1; Y = 36'sd5000; out_ready = 1'b1;
        step();
        step();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_full",      full,      0);
        chk("reset_drop",      drop,      0);
        chk("reset_drop_cnt",  drop_cnt,  0);
        chk("reset_out_data",  out_data,  0);
        chk("reset_out_sat",   out_sat,   0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; Y = '0;

        // Latency with ce gating: in_valid on ce=0 cycles must be ignored.
        ce = 1'b1; in_valid = 1'b1; Y = ymul(99);
        step();
        for (int c = 1; c <= 5; c++) begin
            ce       = (c % 2 == 1);
            in_valid = (c % 2 == 0);
            Y        = (c == 5) ? ymul(3) : ymul(99);
            step();
            if (c < 5) chk($sformatf("lat_no_push_c%0d", c), out_valid, 0);
        end
        chk("lat_push_valid", out_valid, 1);
        chk("lat_push_data",  out_data,  3);
        ce = 1'b1; in_valid = 1'b0; Y = '0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("lat_drained", out_valid, 0);

        // Table of round/saturate vectors, each issued and captured individually.
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1; Y = '0;
            step();
            in_valid = 1'b0;
            step();
            step();
            Y = vecs[k].y;
            step();
            Y = '0;
            chk($sformatf("vec%0d_valid", k), out_valid, 1);
            chk($sformatf("vec%0d_data", k),  out_data,  vecs[k].exp_d);
            chk($sformatf("vec%0d_sat", k),   out_sat,   vecs[k].exp_s);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk($sformatf("vec%0d_empty", k), out_valid, 0);
        end

        // Overflow: six results into a four-entry FIFO with no reader.
        for (int t = 0; t < 9; t++) begin
            in_valid = (t < 6);
            Y        = (t >= 3) ? ymul(t - 2) : '0;
            step();
            if (t == 5) chk("ovf_not_full_3", full, 0);
            if (t == 6) begin
                chk("ovf_full_4", full, 1);
                chk("ovf_no_drop_yet", drop, 0);
            end
        end
        in_valid = 1'b0; Y = '0;
        chk("ovf_full",     full,     1);
        chk("ovf_drop",     drop,     1);
        chk("ovf_drop_cnt", drop_cnt, 2);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovf_rd%0d_valid", k), out_valid, 1);
            chk($sformatf("ovf_rd%0d_data", k),  out_data,  k);
            step();
        end
        chk("ovf_empty_after", out_valid, 0);
        out_ready = 1'b0;

        // Push and pop together while full: no drop, order kept.
        for (int t = 0; t < 9; t++) begin
            in_valid  = (t < 6);
            Y         = (t >= 3) ? ymul(t + 7) : '0;
            out_ready = (t == 7 || t == 8);
            step();
            if (t == 6) chk("pp_full_4", full, 1);
            if (t == 7) chk("pp_full_pushpop", full, 1);
        end
        in_valid = 1'b0; Y = '0;
        chk("pp_full_end",  full,     1);
        chk("pp_drop_cnt",  drop_cnt, 2);
        out_ready = 1'b1;
        for (int k = 12; k <= 15; k++) begin
            chk($sformatf("pp_rd%0d_data", k), out_data, k);
            step();
        end
        chk("pp_empty_after", out_valid, 0);
        out_ready = 1'b0;

        // Reset mid-stream: two queued, two in flight.
        for (int t = 0; t < 5; t++) begin
            in_valid = (t < 4);
            Y        = (t >= 3) ? ymul(t + 1) : '0;
            step();
        end
        chk("rst_pre_valid", out_valid, 1);
        rst = 1'b1; in_valid = 1'b0; Y = ymul(7);
        step();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_full",      full,      0);
        chk("rst_drop",      drop,      0);
        chk("rst_drop_cnt",  drop_cnt,  0);
        chk("rst_out_data",  out_data,  0);
        for (int t = 0; t < 5; t++) begin
            step();
            chk($sformatf("rst_no_stale_push%0d", t), out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
